// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - register map, state encoding and status codes shared by the S2MM write engine
package dma_pkg;

  localparam logic [2:0] REG_DST_ADDR   = 3'd0;
  localparam logic [2:0] REG_ADDR_VALID = 3'd1;
  localparam logic [2:0] REG_ERROR      = 3'd2;
  localparam logic [2:0] REG_LENGTH     = 3'd3;
  localparam logic [2:0] REG_START      = 3'd4;
  localparam logic [2:0] REG_STRIDE     = 3'd5;
  localparam logic [2:0] REG_READY      = 3'd6;
  localparam logic [2:0] REG_COUNT      = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } s2mm_state_enum;

  localparam int ERR_NO_ADDR = 0;
  localparam int ERR_BRESP   = 1;
  localparam int ERR_SHORT   = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/basic_sync_fifo.sv
// rtl/basic_sync_fifo.sv - single-clock FIFO; READ_LATENCY 1 gives registered read data after a pop
module basic_sync_fifo #(
  parameter int DEPTH        = 256,
  parameter int WIDTH        = 33,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_fire;
  logic             rd_fire;

  // The extra pointer bit separates the full and empty cases when the indices match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    rd_data_d = rd_data_q;
    if (wr_fire) begin
      wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (rd_fire) begin
      rptr_d    = rptr_q + {{AW{1'b0}}, 1'b1};
      rd_data_d = mem_q[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rd_data_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wptr_q[AW-1:0]] <= wr_data;
    end
  end

  if (READ_LATENCY == 0) begin : g_show_ahead
    assign rd_data = mem_q[rptr_q[AW-1:0]];
  end else begin : g_registered
    assign rd_data = rd_data_q;
  end

endmodule

// File: rtl/dma_write.sv
// rtl/dma_write.sv - S2MM engine: buffers an input stream and writes each beat to base + k*stride
module dma_write
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ps_wvalid,
  input  logic [2:0]              ps_waddr,
  input  logic [31:0]             ps_wdata,
  output logic                    ps_wready,
  output logic                    ps_wresp,
  input  logic                    ps_arvalid,
  input  logic [2:0]              ps_raddr,
  output logic [31:0]             ps_rdata,
  output logic                    ps_rvalid,
  output logic                    mem_awvalid,
  input  logic                    mem_awready,
  output logic [ADDR_WIDTH-1:0]   mem_awaddr,
  output logic                    mem_wvalid,
  input  logic                    mem_wready,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_bvalid,
  input  logic [1:0]              mem_bresp,
  output logic                    mem_bready,
  input  logic                    din_valid,
  output logic                    din_ready,
  input  logic [DATA_WIDTH-1:0]   din_data,
  input  logic                    din_last
);

  s2mm_state_enum state_q, state_d;

  logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
  logic                  addr_valid_q, addr_valid_d;
  logic [2:0]            error_q, error_d;
  logic [31:0]           length_q, length_d;
  logic [31:0]           stride_q, stride_d;
  logic                  ready_q;
  logic [31:0]           count_q, count_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  ps_wresp_q;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH:0]   fifo_rd_data;

  logic                  start_pulse;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  beat_last;
  logic                  final_beat;

  // The FIFO read register doubles as the beat register: it only changes on the next pop.
  basic_sync_fifo #(
    .DEPTH       (FIFO_DEPTH),
    .WIDTH       (DATA_WIDTH + 1),
    .READ_LATENCY(1)
  ) u_in_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (din_valid),
    .wr_data({din_last, din_data}),
    .full   (fifo_full),
    .rd_en  (fifo_rd_en),
    .rd_data(fifo_rd_data),
    .empty  (fifo_empty)
  );

  assign din_ready   = !fifo_full;
  assign mem_awaddr  = cur_addr_q;
  assign mem_wdata   = fifo_rd_data[DATA_WIDTH-1:0];
  assign mem_wstrb   = '1;
  assign beat_last   = fifo_rd_data[DATA_WIDTH];
  assign ps_wready   = 1'b1;
  assign ps_wresp    = ps_wresp_q;
  assign ps_rvalid   = ps_arvalid;
  assign start_pulse = ps_wvalid && (ps_waddr == REG_START) && ps_wdata[0];
  assign aw_hs       = mem_awvalid && mem_awready;
  assign w_hs        = mem_wvalid && mem_wready;
  assign final_beat  = (count_q + 32'd1) == length_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_pulse && addr_valid_q && (length_q != 32'd0)) begin
          state_d = POP;
        end
      end
      POP: begin
        if (!fifo_empty) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_bvalid) begin
          if ((mem_bresp != RESP_OKAY) || final_beat || beat_last) begin
            state_d = IDLE;
          end else begin
            state_d = POP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_awvalid = (state_q == WRITE) && !aw_done_q;
    mem_wvalid  = (state_q == WRITE) && !w_done_q;
    mem_bready  = (state_q == RESP);
    fifo_rd_en  = (state_q == POP) && !fifo_empty;
  end

  always_comb begin
    dst_addr_d   = dst_addr_q;
    addr_valid_d = addr_valid_q;
    length_d     = length_q;
    stride_d     = stride_q;
    error_d      = error_q;
    count_d      = count_q;
    cur_addr_d   = cur_addr_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;

    // Configuration is frozen while a transfer is in flight.
    if (ps_wvalid && (state_q == IDLE)) begin
      case (ps_waddr)
        REG_DST_ADDR: begin
          dst_addr_d   = ADDR_WIDTH'(ps_wdata);
          addr_valid_d = 1'b1;
        end
        REG_LENGTH: length_d = ps_wdata;
        REG_STRIDE: stride_d = ps_wdata;
        default: ;
      endcase
    end

    if (start_pulse && (state_q == IDLE)) begin
      error_d = '0;
      if (!addr_valid_q) begin
        error_d[ERR_NO_ADDR] = 1'b1;
      end else if (length_q != 32'd0) begin
        cur_addr_d = dst_addr_q;
        count_d    = '0;
      end
    end

    case (state_q)
      POP: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      WRITE: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
      end
      RESP: begin
        if (mem_bvalid) begin
          count_d    = count_q + 32'd1;
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(stride_q);
          if (mem_bresp != RESP_OKAY) begin
            error_d[ERR_BRESP] = 1'b1;
          end else if (!final_beat && beat_last) begin
            error_d[ERR_SHORT] = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst_addr_q   <= '0;
      addr_valid_q <= 1'b0;
      error_q      <= '0;
      length_q     <= '0;
      stride_q     <= '0;
      ready_q      <= 1'b0;
      count_q      <= '0;
      cur_addr_q   <= '0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      ps_wresp_q   <= 1'b0;
    end else begin
      dst_addr_q   <= dst_addr_d;
      addr_valid_q <= addr_valid_d;
      error_q      <= error_d;
      length_q     <= length_d;
      stride_q     <= stride_d;
      ready_q      <= (state_q == IDLE);
      count_q      <= count_d;
      cur_addr_q   <= cur_addr_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      ps_wresp_q   <= ps_wvalid;
    end
  end

  always_comb begin
    ps_rdata = '0;
    case (ps_raddr)
      REG_DST_ADDR:   ps_rdata = 32'(dst_addr_q);
      REG_ADDR_VALID: ps_rdata = {31'd0, addr_valid_q};
      REG_ERROR:      ps_rdata = {29'd0, error_q};
      REG_LENGTH:     ps_rdata = length_q;
      REG_STRIDE:     ps_rdata = stride_q;
      REG_READY:      ps_rdata = {31'd0, ready_q};
      REG_COUNT:      ps_rdata = count_q;
      default:        ps_rdata = '0;
    endcase
  end

endmodule

// File: doc/dma_write.md
Name: dma_write

Overview:
- S2MM DMA engine, the write-direction counterpart of the MM2S read engine.
- Accepts an AXI-Stream input, buffers it in an internal FIFO, and writes each beat to memory through an AXI-Lite master write channel.
- Addresses are base + k*stride. Control and status go through the PS register port, using the same register-map style as the MM2S engine.
- Sits between the PL stream producer and the memory interconnect.

Parameters:
ADDR_WIDTH, 32, memory address width
DATA_WIDTH, 32, stream and memory data width
FIFO_DEPTH, 256, input buffer depth in beats (power of 2)

Ports:
clk  in  1  clock; the only clock
rst_n  in  1  reset; synchronous, active-low
ps_wvalid  in  1  PS register write strobe
ps_waddr  in  3  PS write register index
ps_wdata  in  32  PS write data
ps_wready  out  1  constant 1
ps_wresp  out  1  registered copy of ps_wvalid
ps_arvalid  in  1  PS read strobe
ps_raddr  in  3  PS read register index
ps_rdata  out  32  PS read data (combinational)
ps_rvalid  out  1  equals ps_arvalid
mem_awvalid  out  1  AXI-Lite write address valid
mem_awready  in  1  write address ready
mem_awaddr  out  ADDR_WIDTH  write address
mem_wvalid  out  1  write data valid
mem_wready  in  1  write data ready
mem_wdata  out  DATA_WIDTH  write data
mem_wstrb  out  DATA_WIDTH/8  all ones
mem_bvalid  in  1  write response valid
mem_bresp  in  2  write response code
mem_bready  out  1  write response ready
din_valid  in  1  stream valid
din_ready  out  1  stream ready, equals !fifo_full
din_data  in  DATA_WIDTH  stream data
din_last  in  1  stream last

Behaviour:
- Register map (index: name, access):
  - 0: dst_addr, RW. A write also sets addr_valid=1.
  - 1: addr_valid, RO.
  - 2: error, RO, sticky. Cleared by reset or by a start write.
  - 3: length in beats, RW.
  - 4: start, WO. A write with bit0=1 produces a one-cycle start pulse.
  - 5: stride in bytes, RW.
  - 6: ready, RO. Equals (state==IDLE), registered.
  - 7: count of beats completed, RO.
- Reading an unmapped index returns 0.
- Writes to indices 0, 3 and 5 while state!=IDLE are ignored.
- Error bits:
  - bit0: start issued with addr_valid=0.
  - bit1: mem_bresp!=OKAY received.
  - bit2: din_last popped before length beats were written.
- Reset values: all registers 0; state IDLE; mem_awvalid, mem_wvalid and mem_bready 0; FIFO empty; ps_wresp 0.
- State IDLE:
  - On start pulse with addr_valid=1 and length!=0: cur_addr<=dst_addr, count<=0, go to POP.
  - On start with addr_valid=0: set error bit0 and stay in IDLE.
  - On start with length==0: no memory traffic, stay in IDLE.
  - A start pulse in any other state is ignored.
- State POP: when the FIFO is non-empty, pop one beat, latch it into the data register, and go to WRITE. This costs one cycle (READ_LATENCY 1).
- State WRITE:
  - Assert mem_awvalid and mem_wvalid together.
  - Each valid drops independently once its own ready is sampled high (track aw_done and w_done).
  - Once both are done, go to RESP.
  - awaddr and wdata stay stable while their valid is high.
- State RESP:
  - mem_bready=1. On mem_bvalid: count<=count+1 and cur_addr<=cur_addr+stride (mod 2^ADDR_WIDTH, wraps silently).
  - If bresp!=OKAY: set error bit1 and go to IDLE (abort).
  - Else if count+1==length: go to IDLE.
  - Else if the popped beat had last=1: set error bit2 and go to IDLE.
  - Otherwise go to POP.
- Exactly one outstanding write transaction at a time.
- If din_last arrives on the final beat (count+1==length), the transfer is normal with no error.
- Beats not consumed remain in the FIFO for the next transfer.
- FIFO full: din_ready=0 and the stream is back-pressured; no data is lost.
- FIFO empty in POP: the engine waits indefinitely.
- Simultaneous FIFO push and pop are both allowed in the same cycle.
- Reset mid-transfer: the pending AXI transaction is abandoned, valids are low from the next cycle, and the FIFO is flushed.

Decomposition:
- dma_pkg: register index localparams (0..7), s2mm_state_enum {IDLE, POP, WRITE, RESP}, error bit positions, AXI resp OKAY=2'b00.
- Sub-module: the existing basic_sync_fifo (DEPTH=FIFO_DEPTH, READ_LATENCY=1) as the input buffer.
- FSM and register file live in dma_write.

Test Plan:
1. dst_addr=0x1000, stride=4, length=4, start; stream 4 beats 0xA..0xD with last on the 4th -> awaddr 0x1000,0x1004,0x1008,0x100C carry wdata A..D; ready=1; count=4; error=0.
2. Start without writing dst_addr -> error=0x1, no awvalid ever, ready stays 1.
3. length=8, last on beat 3 -> 3 writes, error=0x4, ready=1, count=3.
4. Memory model: awready delayed 3 cycles, wready immediate, bresp=SLVERR on 2nd write -> awvalid held stable for 3 cycles, exactly 2 writes, error=0x2.
5. 300 beats pushed, mem_awready held 0 -> din_ready drops after 256 buffered beats; release awready -> all 300 written in order at stride=8.
6. Reset asserted during RESP, then a new transfer with length=2 -> all valids 0 during reset, FIFO empty; next transfer writes 2 fresh beats correctly.
